// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM states, pc_sel encodings, defaults.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_ALU = 2'b01;
    localparam logic [1:0] PC_SEL_IMM = 2'b10;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_RESET_PC   = 0;

    // Only the two explicit target encodings change flow; the others are treated as no redirect.
    function automatic logic is_redirect_sel(input logic [1:0] sel);
        return (sel == PC_SEL_ALU) || (sel == PC_SEL_IMM);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: power-of-two circular buffer with synchronous flush and occupancy count.
module fetch_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // NOTE: storage has no reset; validity is tracked by r_count, so clearing it buys nothing.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    // Empty queue presents zeros so the fetch outputs read 0 after reset.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch/prefetch unit with controller back-door writes.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int RESET_PC   = DEF_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect,
    input  logic [1:0]            pc_sel,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [ADDR_WIDTH-1:0] imm_addr,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  cntlr_wr,
    input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
    input  logic [DATA_WIDTH-1:0] cntlr_wr_data,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_flush_cnt,
`endif
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int                    CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]        DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] START_PC  = ADDR_WIDTH'(RESET_PC);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0]            r_pc;
    logic [ADDR_WIDTH-1:0]            r_inflight_pc;
    logic                             r_inflight;
    logic                             w_redirect;
    logic [ADDR_WIDTH-1:0]            w_target;
    logic                             w_pop;
    logic                             w_push;
    logic                             w_empty;
    logic [CNT_W-1:0]                 w_count;
    logic [CNT_W:0]                   w_occ;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_head;

    assign w_redirect = redirect && is_redirect_sel(pc_sel);
    assign w_target   = (pc_sel == PC_SEL_ALU) ? alu_addr : imm_addr;

    assign instr_valid = !w_empty;
    assign w_pop       = instr_valid && instr_ready;
    // A redirect in the same cycle discards the returning response.
    assign w_push      = r_inflight && !w_redirect;

    // Slots committed after this cycle's pop; lets a full queue pop and issue together.
    assign w_occ = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};

    assign mem_raddr   = r_pc;
    assign mem_waddr   = cntlr_waddr;
    assign mem_wr_data = cntlr_wr_data;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;

        case (r_state)
            ST_IDLE:  if (fetch_en) w_state_nxt = ST_RUN;
            ST_RUN:   if (!fetch_en) w_state_nxt = ST_IDLE;
            ST_WRITE: w_state_nxt = fetch_en ? ST_RUN : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (cntlr_wr) w_state_nxt = ST_WRITE;

        // Write owns the memory port: no read is issued in a cycle carrying a write.
        mem_wr_en = cntlr_wr && !rst;
        mem_rd_en = (r_state == ST_RUN) && fetch_en && !cntlr_wr && !w_redirect &&
                    (w_occ < DEPTH_OCC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_pc          <= START_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= mem_rd_en;
            if (mem_rd_en) r_inflight_pc <= r_pc;
            if (w_redirect)     r_pc <= w_target;
            else if (mem_rd_en) r_pc <= r_pc + ADDR_WIDTH'(1);
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_data  ({r_inflight_pc, mem_rd_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign instr_pc   = w_head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign instr_data = w_head[DATA_WIDTH-1:0];

`ifdef FETCH_PERF_CNT_EN
    // A pop that coincides with a flush still counts as a consumed instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_pop)      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (w_redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule
